// File: rtl/gups_mem_arbiter.sv
// gups_mem_arbiter: round-robin arbiter locking one memory port to an engine for a full read-modify-write.
module gups_mem_arbiter #(
  parameter int NUM_ENG = 4,
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int CW = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [CW-1:0]          max_updates,
  input  logic [NUM_ENG-1:0]     eng_req,
  input  logic [NUM_ENG-1:0]     eng_write,
  input  logic [NUM_ENG*AW-1:0]  eng_addr,
  input  logic [NUM_ENG*DW-1:0]  eng_wdata,
  output logic [NUM_ENG-1:0]     eng_ready,
  output logic [DW-1:0]          eng_rdata,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ready,
  input  logic [DW-1:0]          mem_rdata,
  output logic                   busy,
  output logic                   done,
  output logic [CW-1:0]          update_count,
  output logic [CW-1:0]          cycle_count
);
  localparam int GW = $clog2(NUM_ENG);
  typedef enum logic [1:0] {IDLE, RD, WAIT_WR, WR} state_t;
  state_t state, state_n;
  logic [GW-1:0] rr_ptr, rr_ptr_n, grant, grant_n, pick, grant_inc;
  logic found, mem_req_n, mem_write_n, done_n, busy_n;
  logic [NUM_ENG-1:0] elig, eng_ready_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, eng_rdata_n;
  logic [CW-1:0] update_count_n, cycle_count_n;
  int idx;
  assign grant_inc = (grant == GW'(NUM_ENG - 1)) ? '0 : grant + 1'b1;
  // Only engines in their read phase may start a new RMW; scan descending so the nearest to rr_ptr wins.
  always_comb begin
    elig = eng_req & ~eng_write;
    pick = rr_ptr;
    found = 1'b0;
    idx = 0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % NUM_ENG;
      if (elig[idx]) begin
        pick = GW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    rr_ptr_n = rr_ptr;
    grant_n = grant;
    mem_req_n = mem_req;
    mem_write_n = mem_write;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    eng_rdata_n = eng_rdata;
    eng_ready_n = '0;
    update_count_n = update_count;
    done_n = done;
    cycle_count_n = (run && !done && !(&cycle_count)) ? cycle_count + 1'b1 : cycle_count;
    case (state)
      IDLE: if (run && !done && found) begin
        grant_n = pick;
        mem_addr_n = eng_addr[pick*AW +: AW];
        mem_req_n = 1'b1;
        mem_write_n = 1'b0;
        state_n = RD;
      end
      RD: if (mem_ready) begin
        mem_req_n = 1'b0;
        eng_rdata_n = mem_rdata;
        eng_ready_n = NUM_ENG'(1) << grant;
        state_n = WAIT_WR;
      end
      WAIT_WR: if (!eng_req[grant]) begin
        rr_ptr_n = grant_inc;
        state_n = IDLE;
      end else if (eng_write[grant]) begin
        mem_wdata_n = eng_wdata[grant*DW +: DW];
        mem_req_n = 1'b1;
        mem_write_n = 1'b1;
        state_n = WR;
      end
      WR: if (mem_ready) begin
        mem_req_n = 1'b0;
        mem_write_n = 1'b0;
        eng_ready_n = NUM_ENG'(1) << grant;
        update_count_n = update_count + 1'b1;
        rr_ptr_n = grant_inc;
        done_n = done | (max_updates != '0 && update_count_n >= max_updates);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      mem_req <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      eng_rdata <= '0;
      eng_ready <= '0;
      update_count <= '0;
      cycle_count <= '0;
      done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_ptr_n;
      grant <= grant_n;
      mem_req <= mem_req_n;
      mem_write <= mem_write_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      eng_rdata <= eng_rdata_n;
      eng_ready <= eng_ready_n;
      update_count <= update_count_n;
      cycle_count <= cycle_count_n;
      done <= done_n;
      busy <= busy_n;
    end
  end
endmodule
